led_scan_controller: RTL and testbench
======================================

// Module: led_scan_controller
// PURPOSE
//  Upstream of the LED array driver. Column-scan sequencer and double-buffered frame store
//  between the Conway grid and the 8x8 LED matrix. Drives the driver's ena/x/cells inputs.
//  Blanks between columns to suppress ghosting. Swaps in new grid states only at frame
//  boundaries, so a frame is never torn.
// PARAMETERS
//  N             8     grid/LED size; legal 1..8
//  DWELL_CYCLES  1000  clocks ena is held high per column; >=1
//  BLANK_CYCLES  16    clocks ena is held low before each column; 0 = no blanking
// PORTS
//  clk          in   1              system clock, all logic rising-edge
//  rst          in   1              asynchronous, active-low reset
//  scan_en      in   1              1 = run the column scan, 0 = stop and blank the display
//  cells_in     in   N*N            new grid state from the game-of-life core
//  cells_valid  in   1              cells_in is valid
//  cells_ready  out  1              frame store can accept cells_in
//  ena          out  1              to driver: column drive enable
//  x            out  $clog2(N)+1    to driver: active column index, 0..N-1
//  cells        out  N*N            to driver: displayed grid (display buffer)
//  frame_done   out  1              1-cycle pulse when column N-1 finishes driving
// BEHAVIOUR
//  Reset (rst=0, async)
//   - state=S_IDLE; ena=0; x=0; cells=0; frame_done=0; cells_ready=1; pending buffer empty
//   - timer=0; all outputs are registered
//  FSM states: S_IDLE, S_BLANK, S_DRIVE; timer counts clocks spent in the current state
//   - S_IDLE : ena=0, x=0. If scan_en=1, go to S_BLANK next edge
//              (or S_DRIVE when BLANK_CYCLES=0).
//   - S_BLANK: ena=0 for exactly BLANK_CYCLES clocks, then S_DRIVE.
//   - S_DRIVE: ena=1 for exactly DWELL_CYCLES clocks. On the last clock:
//       - x <= (x==N-1) ? 0 : x+1
//       - frame_done=1 if x==N-1
//       - next state is S_BLANK (or S_DRIVE when BLANK_CYCLES=0)
//   - x is stable for the whole blank+drive slot of a column; x only changes while ena=0,
//     except when BLANK_CYCLES=0.
//   - scan_en=0 in any state: S_IDLE next edge; ena=0, x=0, timer=0 within 1 cycle.
//     Resuming always starts at column 0.
//   - Frame period = N*(BLANK_CYCLES+DWELL_CYCLES) clocks.
//   - Timer width is $clog2(max(DWELL,BLANK)+1) bits. Terminal compare is timer==LIMIT-1.
//  Input handshake / double buffer
//   - Transfer on cells_valid & cells_ready: pending <= cells_in, pending_full=1, cells_ready=0.
//   - cells_valid with cells_ready=0 is ignored; the producer holds its data.
//   - Swap: display <= pending, pending_full=0, cells_ready=1 next cycle. Swap occurs on:
//       (a) the frame_done cycle, or
//       (b) any cycle in S_IDLE with pending_full=1.
//   - No pending data at a frame boundary: display is unchanged and is redisplayed.
//   - Accept and swap never coincide, because cells_ready=0 while pending_full=1.
//   - At most one grid is buffered; back-pressure throttles the producer to the frame rate.
//   - Reset mid-frame: pending data is discarded; display is cleared to 0.
// STRUCTURE
//  - Package led_scan_pkg:
//     - typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} scan_state_t
//     - default N, DWELL_CYCLES, BLANK_CYCLES localparams
//  - One sub-module dwell_timer (clk, rst, clr, limit, done): up-counter with a terminal pulse.
//    The FSM, x counter and buffers live in this module.
// TESTING (N=8, DWELL_CYCLES=4, BLANK_CYCLES=2 unless noted)
//  1. Reset: hold rst=0 with random inputs
//     -> ena=0, x=0, cells=0, cells_ready=1, frame_done=0. Async assert mid-drive zeroes ena
//        without a clock edge.
//  2. Scan timing: release reset, scan_en=1
//     -> ena low 2 / high 4 clocks per column; x steps 0..7 then back to 0
//     -> frame_done pulses once every 48 clocks, on the last ena-high clock of x=7.
//  3. Double buffer: send grid 64'hA5 mid-frame
//     -> cells_ready=0 next cycle; cells unchanged until frame_done
//     -> cells=64'hA5 and cells_ready=1 the cycle after frame_done.
//  4. Back-pressure: hold cells_valid=1 with alternating grids
//     -> exactly one accept per 48-clock frame; no grid is lost or torn.
//  5. Stop/resume: scan_en=0 at x=3 -> ena=0, x=0 next cycle; a grid sent while idle
//     appears on cells 2 cycles after its accept; scan_en=1 -> restarts at x=0 after 2 blank clocks.
//  6. BLANK_CYCLES=0, DWELL_CYCLES=1: ena stays 1; x increments every clock; frame_done every 8.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared types and defaults for the LED column-scan controller.
package led_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_t;

  localparam int DEF_N            = 8;
  localparam int DEF_DWELL_CYCLES = 1000;
  localparam int DEF_BLANK_CYCLES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_scan_controller_dwell_timer.sv
// Up-counter that measures clocks spent in the current scan state; done marks
// the final clock (count == limit-1) of the interval.
module dwell_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [TW-1:0] limit,
  output logic [TW-1:0] count,
  output logic          done
);

  logic [TW-1:0] r_count;

  // clr restarts the count for the clock that follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {TW{1'b0}};
    end else if (clr) begin
      r_count <= {TW{1'b0}};
    end else begin
      r_count <= r_count + TW'(1);
    end
  end

  assign count = r_count;
  assign done  = (r_count == (limit - TW'(1)));

endmodule

// File: rtl/led_scan_controller.sv
// Column-scan sequencer with a double-buffered frame store feeding the LED
// matrix driver; new grids are swapped in only at frame boundaries or while idle.
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en,
  input  logic [N*N-1:0]       cells_in,
  input  logic                 cells_valid,
  output logic                 cells_ready,
  output logic                 ena,
  output logic [$clog2(N):0]   x,
  output logic [N*N-1:0]       cells,
  output logic                 frame_done
);

  localparam int            TW       = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam int            XW       = $clog2(N) + 1;
  localparam logic [TW-1:0] DWELL_L  = TW'(DWELL_CYCLES);
  localparam logic [TW-1:0] BLANK_L  = TW'(BLANK_CYCLES);
  localparam logic [XW-1:0] X_LAST   = XW'(N - 1);
  localparam bit            BLANK_EN = (BLANK_CYCLES > 0);

  scan_state_t    r_state, w_state_next;
  logic [XW-1:0]  r_x, w_x_next;
  logic           r_ena, r_frame_done, w_fd_next;
  logic           w_clr, w_done;
  logic [TW-1:0]  w_limit, w_count, w_count_next;
  logic [N*N-1:0] r_pending, r_display;
  logic           r_pending_full, r_cells_ready;
  logic           w_accept, w_swap;

  dwell_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .limit (w_limit),
    .count (w_count),
    .done  (w_done)
  );

  assign w_limit = (r_state == S_BLANK) ? BLANK_L : DWELL_L;

  // Next state, next column and timer restart; frame_done is predicted one
  // clock early so the registered pulse lands on the last drive clock.
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_clr        = 1'b0;
    if (!scan_en) begin
      w_state_next = S_IDLE;
      w_x_next     = {XW{1'b0}};
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = BLANK_EN ? S_BLANK : S_DRIVE;
          w_x_next     = {XW{1'b0}};
          w_clr        = 1'b1;
        end
        S_BLANK: begin
          if (w_done) begin
            w_state_next = S_DRIVE;
            w_clr        = 1'b1;
          end else begin
            w_state_next = S_BLANK;
          end
        end
        S_DRIVE: begin
          if (w_done) begin
            w_state_next = BLANK_EN ? S_BLANK : S_DRIVE;
            w_x_next     = (r_x == X_LAST) ? {XW{1'b0}} : (r_x + XW'(1));
            w_clr        = 1'b1;
          end else begin
            w_state_next = S_DRIVE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_x_next     = {XW{1'b0}};
          w_clr        = 1'b1;
        end
      endcase
    end
    w_count_next = w_clr ? {TW{1'b0}} : (w_count + TW'(1));
    w_fd_next    = (w_state_next == S_DRIVE) && (w_x_next == X_LAST) &&
                   (w_count_next == (DWELL_L - TW'(1)));
  end

  // Scan registers; ena tracks the state being entered so it is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_x          <= {XW{1'b0}};
      r_ena        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_x          <= w_x_next;
      r_ena        <= (w_state_next == S_DRIVE);
      r_frame_done <= w_fd_next;
    end
  end

  assign w_accept = cells_valid & r_cells_ready;
  assign w_swap   = r_pending_full & (r_frame_done | (r_state == S_IDLE));

  // Frame store; accept and swap are mutually exclusive since ready is low while full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending      <= {(N*N){1'b0}};
      r_display      <= {(N*N){1'b0}};
      r_pending_full <= 1'b0;
      r_cells_ready  <= 1'b1;
    end else if (w_accept) begin
      r_pending      <= cells_in;
      r_pending_full <= 1'b1;
      r_cells_ready  <= 1'b0;
    end else if (w_swap) begin
      r_display      <= r_pending;
      r_pending_full <= 1'b0;
      r_cells_ready  <= 1'b1;
    end else begin
      r_pending_full <= r_pending_full;
      r_cells_ready  <= r_cells_ready;
    end
  end

  assign ena         = r_ena;
  assign x           = r_x;
  assign cells       = r_display;
  assign cells_ready = r_cells_ready;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_led_scan_controller.sv
// Bench for led_scan_controller: a slot-arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_led_scan_controller;

  localparam int NN = 8;
  localparam int DD = 4;
  localparam int BB = 2;
  localparam int SLOT = BB + DD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_en = 1'b0;
  logic [63:0] cells_in = 64'd0;
  logic        cells_valid = 1'b0;
  logic        cells_ready, ena, frame_done;
  logic [3:0]  x;
  logic [63:0] cells;

  logic        scan_en2 = 1'b0;
  logic [63:0] cells_in2 = 64'd0;
  logic        cells_valid2 = 1'b0;
  logic        cells_ready2, ena2, frame_done2;
  logic [3:0]  x2;
  logic [63:0] cells2;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  led_scan_controller #(.N(NN), .DWELL_CYCLES(DD), .BLANK_CYCLES(BB)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .cells_in(cells_in),
    .cells_valid(cells_valid), .cells_ready(cells_ready), .ena(ena),
    .x(x), .cells(cells), .frame_done(frame_done)
  );

  led_scan_controller #(.N(NN), .DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .scan_en(scan_en2), .cells_in(cells_in2),
    .cells_valid(cells_valid2), .cells_ready(cells_ready2), .ena(ena2),
    .x(x2), .cells(cells2), .frame_done(frame_done2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] bp_grid(input int k);
    return {32'(k) ^ 32'hC3C3_5A5A, ~32'(k)};
  endfunction

  // Reference model: position p counts clocks since the scan started.
  bit          m_run, m_pf;
  int          m_p;
  logic [63:0] m_pend, m_disp;

  function automatic bit f_fd(input bit run, input int p);
    return run && ((p % SLOT) == SLOT - 1) && (((p / SLOT) % NN) == NN - 1);
  endfunction

  always @(posedge clk or negedge rst) begin : mdl
    bit acc, swp;
    if (!rst) begin
      m_run <= 1'b0; m_p <= 0; m_pf <= 1'b0; m_pend <= 64'd0; m_disp <= 64'd0;
    end else begin
      acc = cells_valid && !m_pf;
      swp = m_pf && (f_fd(m_run, m_p) || !m_run);
      if (swp) begin m_disp <= m_pend; m_pf <= 1'b0; end
      if (acc) begin m_pend <= cells_in; m_pf <= 1'b1; end
      if (scan_en) begin m_p <= m_run ? m_p + 1 : 0; m_run <= 1'b1; end
      else begin m_p <= 0; m_run <= 1'b0; end
    end
  end

  always @(posedge clk) begin : cmp
    int w, c;
    #1;
    if (cmp_on) begin
      w = m_p % SLOT;
      c = (m_p / SLOT) % NN;
      chk("model_ena", {63'd0, ena}, {63'd0, m_run && (w >= BB)});
      chk("model_x", {60'd0, x}, m_run ? 64'(c) : 64'd0);
      chk("model_frame_done", {63'd0, frame_done}, {63'd0, f_fd(m_run, m_p)});
      chk("model_cells", cells, m_disp);
      chk("model_ready", {63'd0, cells_ready}, {63'd0, !m_pf});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cnt, fd_first, fd_last, waited, n_acc, last_acc, k;
    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      scan_en = 1'($urandom_range(0, 1));
      cells_valid = 1'($urandom_range(0, 1));
      cells_in = {$urandom(), $urandom()};
    end
    cmp_on = 1'b1;
    @(negedge clk);
    chk("rst_ena", {63'd0, ena}, 64'd0);
    chk("rst_x", {60'd0, x}, 64'd0);
    chk("rst_cells", cells, 64'd0);
    chk("rst_ready", {63'd0, cells_ready}, 64'd1);
    chk("rst_fd", {63'd0, frame_done}, 64'd0);

    // Scan timing: frame_done every 48 clocks.
    scan_en = 1'b1; cells_valid = 1'b0; cells_in = 64'd0; rst = 1'b1;
    fd_cnt = 0; fd_first = -1; fd_last = -1;
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk);
      if (frame_done) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = i;
        fd_last = i;
      end
      if (i == 1) chk("scan_first_blank", {59'd0, x, ena}, 64'd0);
      if (i == 3) chk("scan_first_drive", {59'd0, x, ena}, 64'd1);
      if (i == 9) chk("scan_col1_drive", {59'd0, x, ena}, 64'h3);
    end
    chk("fd_count", 64'(fd_cnt), 64'd2);
    chk("fd_first", 64'(fd_first), 64'd48);
    chk("fd_last", 64'(fd_last), 64'd96);

    // Double buffer: grid accepted mid-frame, shown only after frame_done.
    repeat (14) @(negedge clk);
    cells_in = 64'hA5; cells_valid = 1'b1;
    @(negedge clk);
    cells_valid = 1'b0; cells_in = 64'hFFFF_0000_DEAD_BEEF;
    chk("db_ready_low", {63'd0, cells_ready}, 64'd0);
    chk("db_cells_held", cells, 64'd0);
    waited = 0;
    while (!frame_done && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk("db_wait_fd", 64'(waited), 64'd33);
    chk("db_cells_at_fd", cells, 64'd0);
    @(negedge clk);
    chk("db_cells_swapped", cells, 64'hA5);
    chk("db_ready_high", {63'd0, cells_ready}, 64'd1);

    // Back-pressure: one accept per frame.
    k = 0; n_acc = 0; last_acc = -1;
    cells_in = bp_grid(0); cells_valid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (cells_ready) begin
        if (n_acc > 0) chk("bp_interval", 64'(i - last_acc), 64'd48);
        last_acc = i; n_acc++;
        @(negedge clk);
        k++; cells_in = bp_grid(k);
      end else begin
        @(negedge clk);
      end
    end
    cells_valid = 1'b0;
    chk("bp_accepts", 64'(n_acc), 64'd4);
    chk("bp_cells", cells, bp_grid(2));

    // Stop at column 3, idle accept, then resume.
    waited = 0;
    while (x != 4'd3 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk("stop_reach_x3", {60'd0, x}, 64'd3);
    scan_en = 1'b0;
    @(negedge clk);
    chk("stop_ena_x", {59'd0, x, ena}, 64'd0);
    repeat (2) @(negedge clk);
    chk("idle_pending_swapped", cells, bp_grid(3));
    chk("idle_ready", {63'd0, cells_ready}, 64'd1);
    cells_in = 64'h1234_5678_9ABC_DEF0; cells_valid = 1'b1;
    @(negedge clk);
    cells_valid = 1'b0;
    chk("idle_cells_old", cells, bp_grid(3));
    @(negedge clk);
    chk("idle_cells_new", cells, 64'h1234_5678_9ABC_DEF0);
    scan_en = 1'b1;
    @(negedge clk);
    chk("resume_blank0", {59'd0, x, ena}, 64'd0);
    @(negedge clk);
    chk("resume_blank1", {59'd0, x, ena}, 64'd0);
    @(negedge clk);
    chk("resume_drive", {59'd0, x, ena}, 64'd1);

    // Asynchronous reset in the middle of a drive slot.
    #2 rst = 1'b0;
    #1;
    chk("async_ena", {63'd0, ena}, 64'd0);
    chk("async_cells", cells, 64'd0);
    chk("async_ready", {63'd0, cells_ready}, 64'd1);
    @(negedge clk);
    scan_en = 1'b0; rst = 1'b1;
    @(negedge clk);

    // No blanking, single-clock dwell.
    chk("nb_idle", {59'd0, x2, ena2}, 64'd0);
    scan_en2 = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("nb_ena", {63'd0, ena2}, 64'd1);
      chk("nb_x", {60'd0, x2}, 64'(i % 8));
      chk("nb_fd", {63'd0, frame_done2}, {63'd0, (i % 8) == 7});
      if (frame_done2) fd_cnt++;
    end
    chk("nb_fd_count", 64'(fd_cnt), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
